// File: rtl/pc_unit_if.sv
// Handshake/bus bundle for pc_unit: fetch-control inputs and PC/status outputs.
// The master side drives control and the slave side (pc_unit) drives status.
interface pc_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic            stall;
    logic [1:0]      pc_sel;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] epc;
    logic            is_c;
    logic            halt_req;
    logic            resume;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next_seq;
    logic             fetch_valid;
    logic             halted;
    logic             misalign;
    logic [XLEN-1:0]  bad_addr;
    logic [CNT_W-1:0] adv_cnt;

    modport master (
        output stall, pc_sel, alu_result, epc, is_c, halt_req, resume,
        input  pc, pc_next_seq, fetch_valid, halted, misalign, bad_addr, adv_cnt
    );

    modport slave (
        input  stall, pc_sel, alu_result, epc, is_c, halt_req, resume,
        output pc, pc_next_seq, fetch_valid, halted, misalign, bad_addr, adv_cnt
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter generator: BOOT/RUN/HALT sequencing, redirect/trap selection,
// misaligned-target trapping with bad-address capture and an advance counter.
module pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
    parameter bit              C_EXT        = 1'b0,
    parameter int unsigned     CNT_W        = 32
) (
    input logic       clk,
    input logic       rst,
    pc_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_t;

    state_t           r_state;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_bad_addr;
    logic             r_fetch_valid;
    logic             r_halted;
    logic             r_misalign;
    logic [CNT_W-1:0] r_adv_cnt;

    logic [XLEN-1:0]  w_inc;
    logic [XLEN-1:0]  w_seq;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_target_clr;
    logic             w_is_redirect;
    logic             w_bad_tgt;
    logic [XLEN-1:0]  w_pc_nxt;

    always_comb begin
        w_inc = (C_EXT && bus.is_c) ? XLEN'(2) : XLEN'(4);
        w_seq = r_pc + w_inc;
    end

    // Sel 1 clears bit0 of the target; sel 3 passes epc unchanged but is still
    // alignment-checked on its bit0-cleared form.
    always_comb begin
        w_target      = (bus.pc_sel == 2'd1) ? bus.alu_result : bus.epc;
        w_is_redirect = (bus.pc_sel == 2'd1) || (bus.pc_sel == 2'd3);
        w_target_clr  = {w_target[XLEN-1:1], 1'b0};
        w_bad_tgt     = w_is_redirect && !C_EXT && w_target_clr[1];
        w_pc_nxt      = w_seq;
        unique case (bus.pc_sel)
            2'd0:    w_pc_nxt = w_seq;
            2'd1:    w_pc_nxt = w_target_clr;
            2'd2:    w_pc_nxt = TRAP_VECTOR;
            2'd3:    w_pc_nxt = bus.epc;
            default: w_pc_nxt = w_seq;
        endcase
        if (w_bad_tgt) begin
            w_pc_nxt = TRAP_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VECTOR;
            r_bad_addr    <= '0;
            r_fetch_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_misalign    <= 1'b0;
            r_adv_cnt     <= '0;
        end else begin
            r_misalign <= 1'b0;
            unique case (r_state)
                S_BOOT: begin
                    r_state       <= S_RUN;
                    r_fetch_valid <= 1'b1;
                    r_halted      <= 1'b0;
                end
                S_RUN: begin
                    if (!bus.stall) begin
                        r_pc      <= w_pc_nxt;
                        r_adv_cnt <= r_adv_cnt + CNT_W'(1);
                        if (w_bad_tgt) begin
                            r_bad_addr <= w_target;
                            r_misalign <= 1'b1;
                        end
                    end
                    // Halt is taken even while stalled; the update above still lands.
                    if (bus.halt_req) begin
                        r_state       <= S_HALT;
                        r_fetch_valid <= 1'b0;
                        r_halted      <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (bus.resume) begin
                        r_state       <= S_RUN;
                        r_fetch_valid <= 1'b1;
                        r_halted      <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_BOOT;
                    r_fetch_valid <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.pc_next_seq = w_seq;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.halted      = r_halted;
    assign bus.misalign    = r_misalign;
    assign bus.bad_addr    = r_bad_addr;
    assign bus.adv_cnt     = r_adv_cnt;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: two instances (C_EXT=0/CNT_W=32 and C_EXT=1/CNT_W=4) driven
// in lockstep, compared against a behavioural model plus directed expectations.
module tb_pc_unit;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk;
    logic rst;

    pc_unit_if #(.XLEN(32), .CNT_W(32)) if0 ();
    pc_unit_if #(.XLEN(32), .CNT_W(4))  if1 ();

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100),
        .C_EXT(1'b0), .CNT_W(32)
    ) u_dut0 (.clk(clk), .rst(rst), .bus(if0));

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100),
        .C_EXT(1'b1), .CNT_W(4)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus mirror
    logic        t_stall, t_is_c, t_halt, t_resume;
    logic [1:0]  t_sel;
    logic [31:0] t_alu, t_epc;

    // Reference model, one slot per instance
    int          m_mode [2];
    logic [31:0] m_pc   [2];
    logic [31:0] m_bad  [2];
    logic [31:0] m_cnt  [2];
    bit          m_mis  [2];
    bit          c_ext  [2] = '{1'b0, 1'b1};
    logic [31:0] c_mask [2] = '{32'hFFFF_FFFF, 32'h0000_000F};

    task automatic drive(input logic st, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] epc, input logic isc, input logic hr, input logic rs);
        t_stall = st; t_sel = sel; t_alu = alu; t_epc = epc; t_is_c = isc; t_halt = hr; t_resume = rs;
        if0.stall = st; if0.pc_sel = sel; if0.alu_result = alu; if0.epc = epc;
        if0.is_c = isc; if0.halt_req = hr; if0.resume = rs;
        if1.stall = st; if1.pc_sel = sel; if1.alu_result = alu; if1.epc = epc;
        if1.is_c = isc; if1.halt_req = hr; if1.resume = rs;
    endtask

    function automatic logic [31:0] seq_of(input int k, input logic [31:0] pc);
        return pc + ((c_ext[k] && t_is_c) ? 32'd2 : 32'd4);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_mode[k] = M_BOOT; m_pc[k] = 32'h0; m_bad[k] = 32'h0;
                m_cnt[k] = 32'h0;   m_mis[k] = 1'b0;
            end else begin
                m_mis[k] = 1'b0;
                if (m_mode[k] == M_RUN && !t_stall) begin
                    logic [31:0] tgt;
                    tgt = (t_sel == 2'd1) ? t_alu : t_epc;
                    case (t_sel)
                        2'd0: m_pc[k] = seq_of(k, m_pc[k]);
                        2'd1: m_pc[k] = t_alu & 32'hFFFF_FFFE;
                        2'd2: m_pc[k] = 32'h100;
                        default: m_pc[k] = t_epc;
                    endcase
                    if ((t_sel == 2'd1 || t_sel == 2'd3) && !c_ext[k] && ((tgt % 4) >= 2)) begin
                        m_pc[k] = 32'h100; m_bad[k] = tgt; m_mis[k] = 1'b1;
                    end
                    m_cnt[k] = (m_cnt[k] + 1) & c_mask[k];
                end
                if (m_mode[k] == M_BOOT) m_mode[k] = M_RUN;
                else if (m_mode[k] == M_RUN && t_halt) m_mode[k] = M_HALT;
                else if (m_mode[k] == M_HALT && t_resume) m_mode[k] = M_RUN;
            end
        end
    endtask

    task automatic chk_inst(input int k, input logic [31:0] pc, input logic fv, input logic hl,
                            input logic mis, input logic [31:0] bad, input logic [31:0] cnt);
        string p;
        p = (k == 0) ? "u0" : "u1";
        check({p, ".pc"}, 64'(pc), 64'(m_pc[k]));
        check({p, ".fetch_valid"}, 64'(fv), 64'(m_mode[k] == M_RUN));
        check({p, ".halted"}, 64'(hl), 64'(m_mode[k] == M_HALT));
        check({p, ".misalign"}, 64'(mis), 64'(m_mis[k]));
        check({p, ".bad_addr"}, 64'(bad), 64'(m_bad[k]));
        check({p, ".adv_cnt"}, 64'(cnt), 64'(m_cnt[k]));
    endtask

    // One clock: check link address, clock, update model, check registered outputs.
    task automatic step();
        #1;
        if (rst) begin
            check("u0.pc_next_seq", 64'(if0.pc_next_seq), 64'(seq_of(0, m_pc[0])));
            check("u1.pc_next_seq", 64'(if1.pc_next_seq), 64'(seq_of(1, m_pc[1])));
        end
        @(posedge clk);
        model_step();
        #1;
        chk_inst(0, if0.pc, if0.fetch_valid, if0.halted, if0.misalign, if0.bad_addr, if0.adv_cnt);
        chk_inst(1, if1.pc, if1.fetch_valid, if1.halted, if1.misalign, if1.bad_addr, 32'(if1.adv_cnt));
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(); step();
        check("rst_pc", 64'(if0.pc), 64'h0);
        check("rst_fv", 64'(if0.fetch_valid), 64'h0);
        check("rst_cnt", 64'(if0.adv_cnt), 64'h0);

        // Boot then sequential run
        rst = 1'b1;
        step();
        check("boot_pc", 64'(if0.pc), 64'h0);
        check("boot_fv", 64'(if0.fetch_valid), 64'h1);
        step(); step(); step();
        check("seq_pc", 64'(if0.pc), 64'd12);
        check("seq_cnt", 64'(if0.adv_cnt), 64'd3);

        // Misaligned redirect traps only without C extension
        drive(1'b0, 2'd1, 32'h0000_0203, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("mis_pc0", 64'(if0.pc), 64'h100);
        check("mis_bad0", 64'(if0.bad_addr), 64'h203);
        check("mis_flag0", 64'(if0.misalign), 64'h1);
        check("mis_cnt0", 64'(if0.adv_cnt), 64'd4);
        check("mis_pc1", 64'(if1.pc), 64'h202);
        check("mis_flag1", 64'(if1.misalign), 64'h0);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("mis_pulse", 64'(if0.misalign), 64'h0);

        // Stall freezes pc and counter
        drive(1'b0, 2'd1, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'd1, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0);
        step(); step(); step();
        check("stall_pc", 64'(if0.pc), 64'h40);
        check("stall_cnt", 64'(if0.adv_cnt), 64'd6);

        // Halt with a same-cycle sequential update, hold, resume
        drive(1'b0, 2'd1, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        check("halt_pc", 64'(if0.pc), 64'h14);
        check("halt_flag", 64'(if0.halted), 64'h1);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("halt_hold", 64'(if0.pc), 64'h14);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("resume_pc", 64'(if0.pc), 64'h18);

        // Address wrap
        drive(1'b0, 2'd1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("wrap4", 64'(if0.pc), 64'h0);
        drive(1'b0, 2'd1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        check("wrap2", 64'(if1.pc), 64'h0);

        // Reset during halt and stall
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check("rh_pc", 64'(if0.pc), 64'h0);
        check("rh_halted", 64'(if0.halted), 64'h0);
        check("rh_cnt", 64'(if0.adv_cnt), 64'h0);
        check("rh_bad", 64'(if0.bad_addr), 64'h0);
        rst = 1'b1;

        // Randomised run against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] alu, epc;
            alu = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
            epc = ($urandom() & 32'h0000_03FE);
            if ($urandom_range(0, 7) == 0) epc = epc | 32'hFFFF_F000;
            drive(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), alu, epc,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) == 0));
            rst = ($urandom_range(0, 79) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
